dcache_sram_bank: RTL and testbench
===================================

Name: dcache_sram_bank

Overview:
- Single-port, synchronous-read RAM macro model used for the L1 data-cache data, tag and valid/dirty arrays.
- Wide words are split internally into 64-bit slices, each with its own byte enables.
- Carries an optional user (sideband) field alongside the data.
- One instance per way for data and per way for tag; one instance holds the packed valid/dirty bits.

Parameters:
- DATA_WIDTH, 64, data word width in bits (any value ≥1; internally padded to a multiple of 64).
- USER_WIDTH, 1, sideband width in bits (≥1).
- NUM_WORDS, 1024, number of addressable words (≥2; need not be a power of two).
- Derived, not overridable:
  - AW = max(1, clog2(NUM_WORDS)).
  - BEW = ceil(DATA_WIDTH/8).
  - NB = ceil(DATA_WIDTH/64).

Ports:
- clk_i  in  1  clock, all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  1  access request; no access happens when low.
- we_i  in  1  1 = write, 0 = read (only meaningful with req_i).
- addr_i  in  AW  word address.
- wdata_i  in  DATA_WIDTH  write data.
- be_i  in  BEW  byte enables; bit k covers wdata_i[8k+7:8k].
- wuser_i  in  USER_WIDTH  write sideband.
- rdata_o  out  DATA_WIDTH  read data.
- ruser_o  out  USER_WIDTH  read sideband.

Behaviour:
- Reset: while rst_i is high, rdata_o=0 and ruser_o=0 and no write occurs. Array contents are not cleared unless the optional feature is compiled in.
- Read (req_i=1, we_i=0): rdata_o and ruser_o show mem[addr_i] on the edge after the request; latency is exactly 1 cycle. Outputs are registered and hold their value until the next read.
- Idle (req_i=0): rdata_o and ruser_o hold their last value.
- Write (req_i=1, we_i=1):
  - Byte k of mem[addr_i] is updated only where be_i[k]=1.
  - The user field is updated only when |be_i=1.
  - rdata_o and ruser_o hold their previous value (no write-through).
  - A write with be_i=0 is a no-op.
- Slicing:
  - wdata_i and be_i are zero-extended to NB*64 and NB*8 bits.
  - Slice j stores bits [64j+63:64j] and takes byte enables [8j+7:8j].
  - rdata_o is the truncation of the concatenated slices.
- Out-of-range address (addr_i ≥ NUM_WORDS): writes are ignored; a read returns 0 on both outputs.
- Read after write to the same address on consecutive cycles returns the newly written data.
- Reset asserted mid-access: the pending read result is discarded and outputs go to 0. A write on an edge where rst_i is high does not happen.
- Reset behaviour does not depend on X on any input.

Optional Feature:
- Macro: DCACHE_SRAM_RESET_CONTENTS_EN.
- Defined: asserting rst_i also clears every array word and user field to 0. Used for FPGA and for simulation without X-propagation.
- Undefined: contents are undefined after power-up and are unaffected by rst_i; only the output registers reset.

Decomposition:
- Shared package dcache_sram_pkg holds:
  - SLICE_W=64.
  - Width-helper functions ceil_div and addr_width.
  - Typedef for the slice byte-enable vector (logic [7:0]).
- One sub-module, dcache_sram_slice: a 64-bit-wide, NUM_WORDS-deep RAM with 8 byte enables and registered read.
- The top instantiates NB slices via generate. It also holds the user-field array, the range check and the output registers.

Test Plan:
- Reset: hold rst_i for 3 cycles then release -> rdata_o=0 and ruser_o=0. With the macro defined, a read of address 5 also returns 0.
- Full write/read: DATA_WIDTH=128, USER_WIDTH=1. Write addr 3 with wdata=0x0123456789ABCDEF_FEDCBA9876543210, be=0xFFFF, wuser=1. Read addr 3 the next cycle -> the same data and ruser_o=1, one cycle after the request.
- Byte enables across slices: with the addr 3 contents above, write addr 3 with wdata all-ones and be=0x0180 -> read returns 0x0123456789ABCDFF_FFDCBA9876543210.
- Hold behaviour: read addr 3, then idle 2 cycles, then write addr 7 -> rdata_o stays equal to the addr 3 value throughout.
- Odd width and range: DATA_WIDTH=4, NUM_WORDS=6. Write 0xA to addr 5 with be=1 -> reads back 0xA. A write to addr 6 is ignored and a read of addr 6 returns 0.
- Zero byte enable: write addr 2 with be=0 after storing 0x55 at addr 2 -> read returns 0x55 and ruser_o is unchanged.

Source files
------------

// File: rtl/dcache_sram_pkg.sv
// Shared definitions for the L1 data-cache SRAM bank.
//   SLICE_W     : width of one internal RAM slice (bits)
//   SLICE_BEW   : byte enables per slice
//   slice_be_t  : byte-enable vector of one slice
//   ceil_div    : integer ceiling division for width derivation
//   addr_width  : address bits for a given depth (never below 1)
package dcache_sram_pkg;
  localparam int SLICE_W   = 64;
  localparam int SLICE_BEW = SLICE_W / 8;

  typedef logic [SLICE_BEW-1:0] slice_be_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/dcache_sram_slice.sv
// One 64-bit wide, NUM_WORDS deep RAM slice with byte enables and a
// registered read port.
// Ports:
//   clk_i, rst_i : clock, async active-high reset (clears the read register)
//   we_i         : write strobe, already qualified by request/range/reset
//   re_i         : read strobe; loads the read register
//   rclr_i       : with re_i, load 0 instead of the array (out-of-range read)
//   addr_i       : word address
//   wdata_i      : write data, be_i : byte enables
//   rdata_o      : registered read data
// Build option DCACHE_SRAM_RESET_CONTENTS_EN: reset also clears the array.
module dcache_sram_slice
  import dcache_sram_pkg::*;
#(
  parameter int NUM_WORDS = 1024,
  parameter int AW        = addr_width(NUM_WORDS)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic               re_i,
  input  logic               rclr_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [SLICE_W-1:0] wdata_i,
  input  slice_be_t          be_i,
  output logic [SLICE_W-1:0] rdata_o
);
  logic [SLICE_W-1:0] mem_q [NUM_WORDS];
  logic [SLICE_W-1:0] rdata_q;

`ifdef DCACHE_SRAM_RESET_CONTENTS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int w = 0; w < NUM_WORDS; w++) mem_q[w] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < SLICE_BEW; b++)
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < SLICE_BEW; b++)
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= rclr_i ? '0 : mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dcache_sram_bank.sv
// Single-port synchronous-read RAM model for L1 D-cache data/tag/state
// arrays. Wide words are stored in 64-bit slices with their own byte
// enables; a sideband user field is written whenever any byte is enabled.
// Ports:
//   clk_i, rst_i       : clock, async active-high reset (outputs go to 0)
//   req_i, we_i        : access request, 1 = write / 0 = read
//   addr_i             : word address; addresses >= NUM_WORDS are ignored on
//                        write and read back as 0
//   wdata_i, be_i      : write data and byte enables
//   wuser_i            : write sideband
//   rdata_o, ruser_o   : registered read data/sideband, held between reads
// Build option DCACHE_SRAM_RESET_CONTENTS_EN: reset also clears all contents.
module dcache_sram_bank
  import dcache_sram_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int USER_WIDTH = 1,
  parameter  int NUM_WORDS  = 1024,
  localparam int AW  = addr_width(NUM_WORDS),
  localparam int BEW = ceil_div(DATA_WIDTH, 8),
  localparam int NB  = ceil_div(DATA_WIDTH, SLICE_W)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BEW-1:0]        be_i,
  input  logic [USER_WIDTH-1:0] wuser_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [USER_WIDTH-1:0] ruser_o
);
  localparam int PAD_W = NB * SLICE_W;

  logic                    in_range, wr_en, rd_en, uwr_en;
  logic [PAD_W-1:0]        wdata_pad, rdata_pad;
  logic [NB*SLICE_BEW-1:0] be_pad;
  logic                    unused_pad;

  logic [USER_WIDTH-1:0] user_mem_q [NUM_WORDS];
  logic [USER_WIDTH-1:0] ruser_q;

  assign in_range = int'(addr_i) < NUM_WORDS;
  // rst_i is gated in so a write coinciding with reset never lands.
  assign wr_en    = req_i & we_i & in_range & ~rst_i;
  assign rd_en    = req_i & ~we_i;
  assign uwr_en   = wr_en & (|be_i);

  always_comb begin
    wdata_pad                 = '0;
    wdata_pad[DATA_WIDTH-1:0] = wdata_i;
    be_pad                    = '0;
    be_pad[BEW-1:0]           = be_i;
  end

  for (genvar g = 0; g < NB; g++) begin : g_slice
    dcache_sram_slice #(.NUM_WORDS(NUM_WORDS), .AW(AW)) u_slice (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (wr_en),
      .re_i    (rd_en),
      .rclr_i  (~in_range),
      .addr_i  (addr_i),
      .wdata_i (wdata_pad[g*SLICE_W +: SLICE_W]),
      .be_i    (be_pad[g*SLICE_BEW +: SLICE_BEW]),
      .rdata_o (rdata_pad[g*SLICE_W +: SLICE_W])
    );
  end

`ifdef DCACHE_SRAM_RESET_CONTENTS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int w = 0; w < NUM_WORDS; w++) user_mem_q[w] <= '0;
    end else if (uwr_en) begin
      user_mem_q[addr_i] <= wuser_i;
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (uwr_en) user_mem_q[addr_i] <= wuser_i;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      ruser_q <= '0;
    else if (rd_en) ruser_q <= in_range ? user_mem_q[addr_i] : '0;
  end

  assign rdata_o    = rdata_pad[DATA_WIDTH-1:0];
  assign ruser_o    = ruser_q;
  // Padding bits above DATA_WIDTH are always zero and intentionally dropped.
  assign unused_pad = ^rdata_pad;
endmodule

// File: tb/tb_dcache_sram_bank.sv
module tb_dcache_sram_bank;
  localparam int OP_I = 0, OP_W = 1, OP_R = 2;
  localparam logic [127:0] D0   = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] D1   = 128'h0123456789ABCDFF_FFDCBA9876543210;
  localparam logic [127:0] ONES = '1;
  localparam logic [127:0] D7   = 128'hDEAD0000BEEF1111_2222333344445555;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  // wide instance: 2 slices, depth not a power of two
  logic         a_req, a_we, a_wuser, a_ruser;
  logic [3:0]   a_addr;
  logic [127:0] a_wdata, a_rdata;
  logic [15:0]  a_be;
  dcache_sram_bank #(.DATA_WIDTH(128), .USER_WIDTH(1), .NUM_WORDS(12)) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(a_req), .we_i(a_we), .addr_i(a_addr),
    .wdata_i(a_wdata), .be_i(a_be), .wuser_i(a_wuser),
    .rdata_o(a_rdata), .ruser_o(a_ruser));

  // narrow instance: odd width, 6 words
  logic         b_req, b_we;
  logic [2:0]   b_addr;
  logic [3:0]   b_wdata, b_rdata;
  logic [0:0]   b_be;
  logic [1:0]   b_wuser, b_ruser;
  dcache_sram_bank #(.DATA_WIDTH(4), .USER_WIDTH(2), .NUM_WORDS(6)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .we_i(b_we), .addr_i(b_addr),
    .wdata_i(b_wdata), .be_i(b_be), .wuser_i(b_wuser),
    .rdata_o(b_rdata), .ruser_o(b_ruser));

  typedef struct {
    int           op;
    logic [3:0]   addr;
    logic [127:0] wd;
    logic [15:0]  be;
    logic [1:0]   wu;
    logic [127:0] ed;
    logic [1:0]   eu;
  } vec_t;

  typedef struct packed {
    logic [127:0] d;
    logic [1:0]   u;
  } exp_t;

  vec_t va[17];
  vec_t vb[11];
  exp_t q[$];
  exp_t hold_a, hold_b;
  int   checks = 0, errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_a(input vec_t v);
    @(negedge clk);
    a_req = (v.op != OP_I); a_we = (v.op == OP_W); a_addr = v.addr;
    a_wdata = v.wd; a_be = v.be; a_wuser = v.wu[0];
    if (v.op == OP_R) q.push_back('{d: v.ed, u: v.eu});
    @(posedge clk); #1;
    if (v.op == OP_R) begin
      if (q.size() == 0) begin check("a_queue_empty", 128'd1, 128'd0); end
      else hold_a = q.pop_front();
    end
    check("a_rdata", a_rdata, hold_a.d);
    check("a_ruser", 128'(a_ruser), 128'(hold_a.u));
  endtask

  task automatic run_b(input vec_t v);
    @(negedge clk);
    b_req = (v.op != OP_I); b_we = (v.op == OP_W); b_addr = v.addr[2:0];
    b_wdata = v.wd[3:0]; b_be = v.be[0:0]; b_wuser = v.wu;
    if (v.op == OP_R) q.push_back('{d: v.ed, u: v.eu});
    @(posedge clk); #1;
    if (v.op == OP_R) begin
      if (q.size() == 0) begin check("b_queue_empty", 128'd1, 128'd0); end
      else hold_b = q.pop_front();
    end
    check("b_rdata", 128'(b_rdata), hold_b.d);
    check("b_ruser", 128'(b_ruser), 128'(hold_b.u));
  endtask

  initial begin
    va[0]  = '{OP_W, 4'd3,  D0,          16'hFFFF, 2'd1, '0,          2'd0};
    va[1]  = '{OP_R, 4'd3,  '0,          16'h0,    2'd0, D0,          2'd1};
    va[2]  = '{OP_W, 4'd3,  ONES,        16'h0180, 2'd0, '0,          2'd0};
    va[3]  = '{OP_R, 4'd3,  '0,          16'h0,    2'd0, D1,          2'd0};
    va[4]  = '{OP_I, 4'd0,  '0,          16'h0,    2'd0, '0,          2'd0};
    va[5]  = '{OP_I, 4'd0,  '0,          16'h0,    2'd0, '0,          2'd0};
    va[6]  = '{OP_W, 4'd7,  D7,          16'hFFFF, 2'd1, '0,          2'd0};
    va[7]  = '{OP_R, 4'd7,  '0,          16'h0,    2'd0, D7,          2'd1};
    va[8]  = '{OP_W, 4'd2,  128'h55,     16'hFFFF, 2'd1, '0,          2'd0};
    va[9]  = '{OP_R, 4'd2,  '0,          16'h0,    2'd0, 128'h55,     2'd1};
    va[10] = '{OP_W, 4'd2,  ONES,        16'h0000, 2'd0, '0,          2'd0};
    va[11] = '{OP_R, 4'd2,  '0,          16'h0,    2'd0, 128'h55,     2'd1};
    va[12] = '{OP_W, 4'd11, 128'hCAFE,   16'hFFFF, 2'd0, '0,          2'd0};
    va[13] = '{OP_R, 4'd11, '0,          16'h0,    2'd0, 128'hCAFE,   2'd0};
    va[14] = '{OP_W, 4'd13, ONES,        16'hFFFF, 2'd1, '0,          2'd0};
    va[15] = '{OP_R, 4'd13, '0,          16'h0,    2'd0, '0,          2'd0};
    va[16] = '{OP_R, 4'd3,  '0,          16'h0,    2'd0, D1,          2'd0};

    vb[0]  = '{OP_W, 4'd5, 128'hA, 16'h1, 2'd2, '0,     2'd0};
    vb[1]  = '{OP_R, 4'd5, '0,     16'h0, 2'd0, 128'hA, 2'd2};
    vb[2]  = '{OP_W, 4'd6, 128'h3, 16'h1, 2'd1, '0,     2'd0};
    vb[3]  = '{OP_R, 4'd6, '0,     16'h0, 2'd0, '0,     2'd0};
    vb[4]  = '{OP_R, 4'd5, '0,     16'h0, 2'd0, 128'hA, 2'd2};
    vb[5]  = '{OP_W, 4'd4, 128'h7, 16'h1, 2'd1, '0,     2'd0};
    vb[6]  = '{OP_W, 4'd4, 128'h5, 16'h0, 2'd3, '0,     2'd0};
    vb[7]  = '{OP_R, 4'd4, '0,     16'h0, 2'd0, 128'h7, 2'd1};
    vb[8]  = '{OP_R, 4'd7, '0,     16'h0, 2'd0, '0,     2'd0};
    vb[9]  = '{OP_W, 4'd0, 128'hF, 16'h1, 2'd3, '0,     2'd0};
    vb[10] = '{OP_R, 4'd0, '0,     16'h0, 2'd0, 128'hF, 2'd3};

    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_be = '0; a_wuser = 0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0; b_wuser = '0;
    hold_a = '0; hold_b = '0;

    // power-on reset held for 3 cycles
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_rdata", a_rdata, '0);
    check("rst_a_ruser", 128'(a_ruser), '0);
    check("rst_b_rdata", 128'(b_rdata), '0);
    check("rst_b_ruser", 128'(b_ruser), '0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_a_rdata", a_rdata, '0);
    check("post_rst_b_rdata", 128'(b_rdata), '0);
`ifdef DCACHE_SRAM_RESET_CONTENTS_EN
    run_b('{OP_R, 4'd5, '0, 16'h0, 2'd0, '0, 2'd0});
    run_b('{OP_I, 4'd0, '0, 16'h0, 2'd0, '0, 2'd0});
`endif

    foreach (va[i]) run_a(va[i]);
    @(negedge clk) a_req = 0;

    // reset arrives with a read in flight: result dropped, outputs cleared
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 4'd3; rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_a_rdata", a_rdata, '0);
    check("midrst_a_ruser", 128'(a_ruser), '0);
    // write attempted while reset is high must not land
    @(negedge clk);
    a_we = 1; a_wdata = ONES; a_be = 16'hFFFF; a_wuser = 1;
    @(posedge clk); #1;
    check("rstwr_a_rdata", a_rdata, '0);
    @(negedge clk) begin rst = 1'b0; a_req = 0; a_we = 0; end
    hold_a = '0;
`ifdef DCACHE_SRAM_RESET_CONTENTS_EN
    run_a('{OP_R, 4'd3, '0, 16'h0, 2'd0, '0, 2'd0});
`else
    run_a('{OP_R, 4'd3, '0, 16'h0, 2'd0, D1, 2'd0});
`endif
    @(negedge clk) a_req = 0;

    foreach (vb[i]) run_b(vb[i]);
    @(negedge clk) b_req = 0;

    check("queue_drained", 128'(q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
